pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 130 +++++++++++++
 tb/tb_pc_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch front end: one outstanding imem request, single-entry
// instruction hold register, branch/jump redirect with in-flight squash.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | out of reset, no request issued yet
// REQ    | request presented at pc, waiting for imem_req_ready
// WAIT   | request accepted, waiting for imem_rsp_valid
// HOLD   | instruction held for the decoder until inst_ready
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        misalign_q, misalign_d;

  logic redir_ok;
  logic redir_bad;

  // A misaligned target is treated as if no redirect happened at all.
  assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    squash_d    = squash_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    misalign_d  = redir_bad;

    if (redir_ok) begin
      pc_d = redirect_target;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // The accepted request was for the old pc; drop its response.
          if (redir_ok) begin
            squash_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (squash_q || redir_ok) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            inst_data_d = imem_rsp_data;
            inst_pc_d   = pc_q;
            pc_d        = pc_q + 32'd4;
            state_d     = S_HOLD;
          end
        end else if (redir_ok) begin
          squash_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (redir_ok || inst_ready) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      squash_q    <= 1'b0;
      inst_data_q <= 32'h0;
      inst_pc_q   <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      squash_q    <= squash_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, decoder stall, redirect
// squash, misaligned redirect, pc wrap and asynchronous reset mid-fetch.
module tb_pc_fetch;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        misalign_err;

  int total;
  int passed;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .misalign_err    (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    total           = 0;
    passed          = 0;
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    inst_ready      = 1'b1;

    step();
    step();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);

    // sequential fetch from reset
    reset = 1'b0;
    step();                                   // IDLE -> REQ
    chk("req0_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("req0_addr", imem_req_addr, 32'h0);
    step();                                   // REQ -> WAIT
    chk("wait0_req_valid", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0040_0093;
    step();                                   // WAIT -> HOLD
    imem_rsp_valid = 1'b0;
    chk("hold0_valid", {31'b0, inst_valid}, 32'd1);
    chk("hold0_pc", inst_pc, 32'h0);
    chk("hold0_data", inst_data, 32'h0040_0093);
    step();                                   // HOLD -> REQ
    chk("req1_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("req1_addr", imem_req_addr, 32'h4);
    chk("req1_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();                                   // REQ -> WAIT
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0080_0113;
    inst_ready     = 1'b0;
    step();                                   // WAIT -> HOLD
    imem_rsp_valid = 1'b0;
    chk("hold1_pc", inst_pc, 32'h4);
    chk("hold1_data", inst_data, 32'h0080_0113);

    // decoder stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("stall_pc", inst_pc, 32'h4);
      chk("stall_data", inst_data, 32'h0080_0113);
    end
    inst_ready = 1'b1;
    step();                                   // HOLD -> REQ
    chk("req2_addr", imem_req_addr, 32'h8);
    chk("req2_valid", {31'b0, imem_req_valid}, 32'd1);

    // redirect to 0x100 while waiting on the 0x8 response
    step();                                   // REQ -> WAIT
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    step();                                   // stays WAIT, squash set
    redirect_valid = 1'b0;
    chk("redir_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("redir_wait_inst_valid", {31'b0, inst_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    step();                                   // stale response dropped
    imem_rsp_valid = 1'b0;
    chk("drop_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("drop_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("drop_req_addr", imem_req_addr, 32'h100);
    step();                                   // REQ -> WAIT
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    step();                                   // WAIT -> HOLD
    imem_rsp_valid = 1'b0;
    chk("redir_inst_pc", inst_pc, 32'h100);
    chk("redir_inst_data", inst_data, 32'h1234_5678);
    step();                                   // HOLD -> REQ
    chk("req_104_addr", imem_req_addr, 32'h104);

    // misaligned redirect is ignored and flagged for one cycle
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    chk("misalign_pulse", {31'b0, misalign_err}, 32'd1);
    chk("misalign_addr", imem_req_addr, 32'h104);
    chk("misalign_req_valid", {31'b0, imem_req_valid}, 32'd1);
    step();
    chk("misalign_clear", {31'b0, misalign_err}, 32'd0);
    chk("misalign_addr2", imem_req_addr, 32'h104);
    imem_req_ready = 1'b1;
    step();                                   // REQ -> WAIT
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hAAAA_0001;
    step();                                   // WAIT -> HOLD
    imem_rsp_valid = 1'b0;
    chk("seq_inst_pc", inst_pc, 32'h104);
    step();                                   // HOLD -> REQ
    chk("seq_req_addr", imem_req_addr, 32'h108);

    // redirect while the request is accepted, target at top of address space
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();                                   // REQ -> WAIT with squash
    redirect_valid = 1'b0;
    chk("acc_redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD1_BAD1;
    step();                                   // squashed response dropped
    imem_rsp_valid = 1'b0;
    chk("acc_redir_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("acc_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();                                   // REQ -> WAIT
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    step();                                   // WAIT -> HOLD
    imem_rsp_valid = 1'b0;
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_data", inst_data, 32'hCAFE_F00D);
    step();                                   // HOLD -> REQ
    chk("wrap_req_addr", imem_req_addr, 32'h0);
    chk("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);

    // redirect in REQ without acceptance keeps requesting at the new target
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    chk("req_redir_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("req_redir_addr", imem_req_addr, 32'h200);
    imem_req_ready = 1'b1;
    step();                                   // REQ -> WAIT for 0x200

    // asynchronous reset with a fetch outstanding
    #2;
    reset = 1'b1;
    #1;
    chk("async_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("async_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("async_req_addr", imem_req_addr, 32'h0);
    chk("async_inst_data", inst_data, 32'h0);
    chk("async_inst_pc", inst_pc, 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    step();
    chk("rst_late_rsp_inst_valid", {31'b0, inst_valid}, 32'd0);
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    step();                                   // IDLE -> REQ, response ignored
    chk("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0);
    chk("post_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();                                   // response in REQ ignored
    chk("req_rsp_ignored", {31'b0, inst_valid}, 32'd0);
    chk("req_rsp_ignored_data", inst_data, 32'h0);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    step();                                   // REQ -> WAIT
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    step();                                   // WAIT -> HOLD
    imem_rsp_valid = 1'b0;
    chk("post_rst_inst_pc", inst_pc, 32'h0);
    chk("post_rst_inst_data", inst_data, 32'h0000_0013);
    chk("post_rst_hold_valid", {31'b0, inst_valid}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
